uart_rx_ctrl: RTL and testbench

UART receive front-end that deserialises the asynchronous `rx_i` line into parallel words and pushes them into the write port of the UART async FIFO. It sits directly upstream of the FIFO write controller in the receive-clock domain. It presents a write strobe plus data, and it respects the FIFO `full` flag itself, so no word is ever offered to a full FIFO. Framing, parity and overrun errors are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity-mode constants, default baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no flow control.
// Reset value is a parameter so idle-high serial lines come out of reset inactive.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver feeding the async FIFO write port; strobe/error pulse one cycle after stop sample.
// Honours full_i itself: a good word arriving while full is dropped and flagged as overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DLY          = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic                  full_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]   HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   FULL_M1  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(DATA_WIDTH - 1);
  localparam bit ODD_SEL = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  // Register delays are a simulation-only notion; the synthesised flops are zero-delay.
  if (CLKS_PER_BIT < 4 || DLY < 0) begin : g_cfg_check
    $error("uart_rx_ctrl: CLKS_PER_BIT must be >= 4 and DLY non-negative");
  end

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_t             state, state_nxt;
  logic [BW-1:0]         baud_cnt, baud_nxt;
  logic [BITW-1:0]       bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                  par_err, par_err_nxt;
  logic                  wr_en_nxt, frame_err_nxt, parity_err_nxt, overrun_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic                  bit_tick;

  assign bit_tick = (baud_cnt == FULL_M1);
  assign busy_o   = (state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_err      <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_data_o    <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      baud_cnt     <= baud_nxt;
      bit_cnt      <= bit_nxt;
      shift_reg    <= shift_nxt;
      par_err      <= par_err_nxt;
      wr_en_o      <= wr_en_nxt;
      wr_data_o    <= wr_data_nxt;
      frame_err_o  <= frame_err_nxt;
      parity_err_o <= parity_err_nxt;
      overrun_o    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    baud_nxt       = baud_cnt + BW'(1);
    bit_nxt        = bit_cnt;
    shift_nxt      = shift_reg;
    par_err_nxt    = par_err;
    wr_en_nxt      = 1'b0;
    wr_data_nxt    = wr_data_o;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;
    overrun_nxt    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        baud_nxt    = '0;
        par_err_nxt = 1'b0;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (baud_cnt == HALF_M1) begin
          baud_nxt = '0;
          bit_nxt  = '0;
          // A line that is high again at mid-start was only a glitch.
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          baud_nxt  = '0;
          shift_nxt = {rx_s, shift_reg[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_cnt + BITW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          baud_nxt    = '0;
          par_err_nxt = (rx_s != ((^shift_reg) ^ ODD_SEL));
          state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          baud_nxt = '0;
          if (rx_s) begin
            state_nxt = ST_IDLE;
            if (par_err) begin
              parity_err_nxt = 1'b1;
            end else if (full_i) begin
              overrun_nxt = 1'b1;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_data_nxt = shift_reg;
            end
          end else begin
            // Framing error wins over parity; wait out any break before re-arming.
            frame_err_nxt = 1'b1;
            state_nxt     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        baud_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance driven bit-by-bit.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic full = 1'b0;

  logic       wr_en0, fe0, pe0, ov0, busy0;
  logic [7:0] wd0;
  logic       wr_en1, fe1, pe1, ov1, busy1;
  logic [7:0] wd1;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0), .full_i(full),
    .wr_en_o(wr_en0), .wr_data_o(wd0), .frame_err_o(fe0),
    .parity_err_o(pe0), .overrun_o(ov0), .busy_o(busy0));

  uart_rx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1), .full_i(full),
    .wr_en_o(wr_en1), .wr_data_o(wd1), .frame_err_o(fe1),
    .parity_err_o(pe1), .overrun_o(ov1), .busy_o(busy1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_n[2], fe_n[2], pe_n[2], ov_n[2];
  int wr_cyc0 = 0;
  int onehot_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en0) begin wr_n[0]++; wr_cyc0 = cyc; end
    if (fe0) fe_n[0]++;
    if (pe0) pe_n[0]++;
    if (ov0) ov_n[0]++;
    if (wr_en1) wr_n[1]++;
    if (fe1) fe_n[1]++;
    if (pe1) pe_n[1]++;
    if (ov1) ov_n[1]++;
    if ($countones({wr_en0, fe0, pe0, ov0}) > 1) onehot_bad++;
    if ($countones({wr_en1, fe1, pe1, ov1}) > 1) onehot_bad++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input int n);
    if (s == 0) rx0 = v; else rx1 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input int s, input logic [7:0] d);
    drive(s, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(s, d[i], CPB);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       full;
    int         e_wr, e_fe, e_pe, e_ov;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[6];
  int b_wr, b_fe, b_pe, b_ov, t0;

  task automatic snap(input int s);
    b_wr = wr_n[s]; b_fe = fe_n[s]; b_pe = pe_n[s]; b_ov = ov_n[s];
  endtask

  initial begin
    vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'hA5};
    vt[1] = '{0, 8'h81, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1, 8'hA5};
    vt[2] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 8'hA5};
    vt[3] = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h55};
    vt[4] = '{1, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 8'h00};
    vt[5] = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h3C};

    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", {wr_en0, wr_en1}, 0);
    check("reset_wr_data", {wd0, wd1}, 0);
    check("reset_errors", {fe0, pe0, ov0, fe1, pe1, ov1}, 0);
    check("reset_busy", {busy0, busy1}, 0);
    rst = 1'b0;
    drive(0, 1'b1, 8);

    for (int k = 0; k < 6; k++) begin
      snap(vt[k].sel);
      full = vt[k].full;
      t0 = cyc;
      send_char(vt[k].sel, vt[k].data);
      if (vt[k].sel == 1) drive(1, vt[k].par, CPB);
      drive(vt[k].sel, vt[k].stop, CPB);
      full = 1'b0;
      drive(vt[k].sel, 1'b1, 8);
      if (k == 0)
        check("latency_in_window", int'((wr_cyc0 - t0) >= 150 && (wr_cyc0 - t0) <= 165), 1);
      check($sformatf("vec%0d_wr", k), wr_n[vt[k].sel] - b_wr, vt[k].e_wr);
      check($sformatf("vec%0d_frame", k), fe_n[vt[k].sel] - b_fe, vt[k].e_fe);
      check($sformatf("vec%0d_parity", k), pe_n[vt[k].sel] - b_pe, vt[k].e_pe);
      check($sformatf("vec%0d_overrun", k), ov_n[vt[k].sel] - b_ov, vt[k].e_ov);
      check($sformatf("vec%0d_data", k), (vt[k].sel == 1) ? wd1 : wd0, vt[k].e_data);
    end

    // Start glitch: 4 low cycles, busy until the mid-start sample, then quiet.
    snap(0);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 4);
    check("glitch_busy_mid", busy0, 1);
    drive(0, 1'b1, 8);
    check("glitch_busy_after", busy0, 0);
    check("glitch_no_pulses", (wr_n[0] - b_wr) + (fe_n[0] - b_fe) + (pe_n[0] - b_pe) + (ov_n[0] - b_ov), 0);

    // Framing error followed by a 40-cycle break, then a clean frame.
    snap(0);
    send_char(0, 8'h3C);
    drive(0, 1'b0, CPB + 40);
    check("break_frame_err", fe_n[0] - b_fe, 1);
    check("break_no_write", wr_n[0] - b_wr, 0);
    check("break_still_busy", busy0, 1);
    drive(0, 1'b1, 8);
    check("break_released", busy0, 0);
    snap(0);
    send_char(0, 8'h55);
    drive(0, 1'b1, CPB + 8);
    check("after_break_wr", wr_n[0] - b_wr, 1);
    check("after_break_data", wd0, 8'h55);

    // Reset in the middle of data bit 3 of 0xF0.
    snap(0);
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, CPB);
    drive(0, 1'b0, CPB / 2);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {wr_en0, fe0, pe0, ov0, busy0}, 0);
    check("midrst_data", wd0, 0);
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b1, 20);
    send_char(0, 8'h0F);
    drive(0, 1'b1, CPB + 8);
    check("midrst_next_wr", wr_n[0] - b_wr, 1);
    check("midrst_next_data", wd0, 8'h0F);
    check("midrst_no_errors", (fe_n[0] - b_fe) + (pe_n[0] - b_pe) + (ov_n[0] - b_ov), 0);

    check("pulses_mutually_exclusive", onehot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
